// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, multi-cycle MDU stall,
// branch flush, plus stall/flush performance counters.
module hazard_ctrl #(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int CW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memread_ex,
    input  logic          rf_we_ex,
    input  logic [AW-1:0] rf_wa_ex,
    input  logic [AW-1:0] rf_ra0_id,
    input  logic [AW-1:0] rf_ra1_id,
    input  logic          npc_sel_ex,
    input  logic          mdu_start_ex,
    output logic          stall_pc,
    output logic          stall_if_id,
    output logic          stall_id_ex,
    output logic          flush_if_id,
    output logic          flush_id_ex,
    output logic          flush_ex_mem,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    typedef enum logic {IDLE, BUSY} mdu_st_e;

    mdu_st_e       st_q, st_d;
    logic [3:0]    md_cnt_q, md_cnt_d;
    logic [1:0]    lu_cnt_q, lu_cnt_d;
    logic [CW-1:0] stall_cnt_q, flush_cnt_q;
    logic          lu_hit, lu_act, mdu_stall;

    always_comb begin
        lu_hit = memread_ex && rf_we_ex && (rf_wa_ex != '0) &&
                 ((rf_wa_ex == rf_ra0_id) || (rf_wa_ex == rf_ra1_id));
        lu_act = lu_hit || (lu_cnt_q != 2'd0);
        mdu_stall = ((st_q == IDLE) && mdu_start_ex) ||
                    ((st_q == BUSY) && (md_cnt_q != 4'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= IDLE;
            md_cnt_q <= 4'd0;
        end else begin
            st_q     <= st_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        md_cnt_d = md_cnt_q;
        case (st_q)
            IDLE: begin
                if (mdu_start_ex) begin
                    st_d     = BUSY;
                    md_cnt_d = 4'(MDU_LAT - 2);
                end
            end
            BUSY: begin
                if (md_cnt_q != 4'd0) md_cnt_d = md_cnt_q - 4'd1;
                else                  st_d     = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    // Lower-priority events leave their counter untouched while outranked.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (!mdu_stall) begin
            if (lu_hit)                lu_cnt_d = 2'(LOAD_LAT - 1);
            else if (lu_cnt_q != 2'd0) lu_cnt_d = lu_cnt_q - 2'd1;
            else if (npc_sel_ex)       lu_cnt_d = 2'd0;
        end
    end

    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (rst) begin
            stall_pc = 1'b0;
        end else if (mdu_stall) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (lu_act) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
        end else if (npc_sel_ex) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_q    <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            if (stall_pc)    stall_cnt_q <= stall_cnt_q + CW'(1);
            if (flush_if_id) flush_cnt_q <= flush_cnt_q + CW'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL expose parameter AW, default 5, register address width.
REQ-002 The block SHALL expose parameter LOAD_LAT, default 1, load-use bubble cycles; legal range 1..3.
REQ-003 The block SHALL expose parameter MDU_LAT, default 4, cycles a multi-cycle mul/div op occupies EX; legal range 2..15.
REQ-004 The block SHALL expose parameter CW, default 32, width of the performance counters.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Ports, in order (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- memread_ex  in  1  load in EX
- rf_we_ex  in  1  EX instruction writes RF
- rf_wa_ex  in  AW  EX destination register
- rf_ra0_id  in  AW  ID source 0
- rf_ra1_id  in  AW  ID source 1
- npc_sel_ex  in  1  taken branch/jump resolved in EX
- mdu_start_ex  in  1  multi-cycle MDU op present in EX
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID
- stall_id_ex  out  1  hold ID/EX
- flush_if_id  out  1  bubble IF/ID
- flush_id_ex  out  1  bubble ID/EX
- flush_ex_mem  out  1  bubble EX/MEM
- stall_cnt  out  CW  cycles with stall_pc=1
- flush_cnt  out  CW  cycles with a branch flush

Function
REQ-007 Load-use hit SHALL be memread_ex & rf_we_ex & rf_wa_ex!=0 & (rf_wa_ex==rf_ra0_id | rf_wa_ex==rf_ra1_id).
REQ-008 On a hit, stall_pc, stall_if_id and flush_id_ex SHALL be 1 in that cycle, and a down-counter lu_cnt SHALL load LOAD_LAT-1.
REQ-009 While lu_cnt!=0, stall_pc, stall_if_id and flush_id_ex SHALL be 1, and lu_cnt SHALL decrement by 1 per cycle, giving exactly LOAD_LAT stall cycles per hit.
REQ-010 The MDU FSM SHALL have states IDLE and BUSY, with a counter md_cnt of width 4.
REQ-011 In IDLE with mdu_start_ex=1, the FSM SHALL assert stall_pc, stall_if_id, stall_id_ex and flush_ex_mem, move to BUSY, and load md_cnt=MDU_LAT-2.
REQ-012 In BUSY with md_cnt!=0, the FSM SHALL assert the same four outputs and decrement md_cnt.
REQ-013 In BUSY with md_cnt==0, the FSM SHALL assert no MDU stall and return to IDLE; this is the completion cycle, and EX advances.
REQ-014 mdu_start_ex SHALL be ignored in BUSY, giving exactly MDU_LAT-1 stall cycles per op.
REQ-015 A branch (npc_sel_ex=1) SHALL assert flush_if_id and flush_id_ex and clear lu_cnt to 0.
REQ-016 Priority SHALL be: MDU stall > load-use (hit or lu_cnt!=0) > branch. A lower-priority event in the same cycle produces no outputs, and its counter state is not updated.
REQ-017 stall_id_ex and flush_ex_mem SHALL be 1 only during MDU stall cycles.
REQ-018 All control outputs SHALL be 0 when no condition is active.
REQ-019 stall_cnt SHALL increment on every clock edge where stall_pc=1.
REQ-020 flush_cnt SHALL increment on every clock edge where flush_if_id=1.
REQ-021 Both counters SHALL wrap modulo 2^CW.

Reset
REQ-022 rst=1 SHALL asynchronously set the FSM to IDLE and clear lu_cnt, md_cnt, stall_cnt and flush_cnt to 0.
REQ-023 While rst=1, all control outputs SHALL be forced to 0.
REQ-024 Reset asserted mid-stall SHALL abort the stall, and the block SHALL resume in IDLE on the first edge after deassertion.

Verification
REQ-025 LOAD_LAT=1, load to r5 in EX, rf_ra1_id=5 -> stall_pc/stall_if_id/flush_id_ex high for 1 cycle; stall_cnt=1.
REQ-026 LOAD_LAT=3, same hit, then memread_ex=0 -> stall outputs high for 3 consecutive cycles; stall_cnt=3.
REQ-027 rf_wa_ex=0 with a matching source and memread_ex=1 -> no stall; counters stay 0.
REQ-028 MDU_LAT=4, mdu_start_ex held for 4 cycles -> stall_pc/stall_id_ex/flush_ex_mem high for cycles 1-3, low in cycle 4; FSM back in IDLE.
REQ-029 npc_sel_ex=1 for 1 cycle -> flush_if_id and flush_id_ex high, no stall; flush_cnt=1. With mdu_start_ex=1 in the same cycle, only the MDU stall occurs.
REQ-030 CW=4, 17 stall cycles -> stall_cnt wraps to 1. rst pulsed during an MDU stall -> all outputs 0 immediately, counters 0.
